// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and helpers for the multi-source forwarding / hazard unit.
package forwarding_hazard_unit_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } forwarding_type_t;

    typedef forwarding_type_t forwarding_t;

    typedef struct packed {
        logic             reg_we;
        logic [REG_W-1:0] rd;
        logic             data_ready;
    } src_bundle_t;

    function automatic int unsigned fwd_sel_width(int unsigned num_stages);
        return $clog2(num_stages + 1);
    endfunction

    // x0 is hard-wired, so a write to it can never satisfy a read.
    function automatic logic match(logic reg_we, logic [REG_W-1:0] rs, logic [REG_W-1:0] rd);
        return reg_we && (rs != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Decode / writer-stage / multi-cycle bus between the pipeline and the hazard unit.
interface forwarding_hazard_unit_if
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_RS     = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned FWD_W = fwd_sel_width(NUM_STAGES);

    logic                             id_valid;
    logic [NUM_RS-1:0][REG_W-1:0]     id_rs;
    logic [NUM_RS-1:0]                id_rs_used;
    logic [REG_W-1:0]                 id_rd;
    logic                             id_is_mc;
    logic                             flush;
    logic [NUM_STAGES-1:0]            stg_reg_we;
    logic [NUM_STAGES-1:0][REG_W-1:0] stg_rd;
    logic [NUM_STAGES-1:0]            stg_data_ready;
    logic                             mc_done;
    logic [REG_W-1:0]                 mc_done_rd;
    logic                             stall;
    logic [NUM_RS-1:0][FWD_W-1:0]     forward_rs;
    logic                             mc_busy;
    logic [CNT_WIDTH-1:0]             stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_is_mc, flush,
               stg_reg_we, stg_rd, stg_data_ready, mc_done, mc_done_rd,
        input  stall, forward_rs, mc_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_is_mc, flush,
               stg_reg_we, stg_rd, stg_data_ready, mc_done, mc_done_rd,
        output stall, forward_rs, mc_busy, stall_cycles
    );

endinterface

// File: rtl/forwarding_hazard_unit_mc_scoreboard.sv
// Tracks destinations of outstanding multi-cycle ops and how many are in flight.
module forwarding_hazard_unit_mc_scoreboard
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned MC_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_issue,
    input  logic [REG_W-1:0]    i_issue_rd,
    input  logic                i_done,
    input  logic [REG_W-1:0]    i_done_rd,
    output logic [NUM_REGS-1:0] o_busy_eff_c,
    output logic                o_full_c,
    output logic                o_busy_c
);
    localparam int unsigned OUT_W = $clog2(MC_DEPTH + 1);

    logic [NUM_REGS-1:0] r_busy;
    logic [OUT_W-1:0]    r_outstanding;
    logic                w_done_ok;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [OUT_W-1:0]    w_outstanding_nxt;

    // A completing op releases its register in the same cycle it finishes.
    always_comb begin
        o_busy_eff_c = r_busy;
        if (i_done) begin
            o_busy_eff_c[i_done_rd] = 1'b0;
        end
    end

    assign o_full_c  = (r_outstanding == OUT_W'(MC_DEPTH)) && !i_done;
    assign o_busy_c  = (r_outstanding != '0);
    assign w_done_ok = i_done && (r_outstanding != '0);

    // Clear before set so a same-register issue/done pair leaves the bit set.
    always_comb begin
        w_busy_nxt        = r_busy;
        w_outstanding_nxt = r_outstanding;
        if (w_done_ok) begin
            w_busy_nxt[i_done_rd] = 1'b0;
        end
        if (i_issue && (i_issue_rd != '0)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        if (i_issue && !w_done_ok) begin
            w_outstanding_nxt = r_outstanding + OUT_W'(1);
        end else if (!i_issue && w_done_ok) begin
            w_outstanding_nxt = r_outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_busy        <= '0;
            r_outstanding <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_outstanding <= w_outstanding_nxt;
            assert (!i_done || (r_outstanding != '0));
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// RAW forwarding selects, load-use / multi-cycle stall and stall-cycle counter.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_RS     = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned MC_DEPTH   = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    forwarding_hazard_unit_if.slave bus
);
    localparam int unsigned FWD_W = fwd_sel_width(NUM_STAGES);

    src_bundle_t [NUM_STAGES-1:0] w_stg;
    logic [NUM_RS-1:0][FWD_W-1:0] w_sel;
    logic [NUM_RS-1:0]            w_load_use;
    logic [NUM_RS-1:0]            w_src_busy;
    logic [NUM_REGS-1:0]          w_busy_eff;
    logic                         w_full;
    logic                         w_mc_busy;
    logic                         w_sb_hazard;
    logic                         w_stall;
    logic                         w_accept;
    logic                         w_issue;
    logic [NUM_RS-1:0][FWD_W-1:0] r_forward_rs;
    logic [CNT_WIDTH-1:0]         r_stall_cycles;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stg
        assign w_stg[s] = '{reg_we:     bus.stg_reg_we[s],
                            rd:         bus.stg_rd[s],
                            data_ready: bus.stg_data_ready[s]};
    end

    // Scan oldest to youngest so the youngest match is the last one written.
    for (genvar i = 0; i < NUM_RS; i++) begin : g_src
        logic [FWD_W-1:0] w_code;
        logic             w_pending;

        always_comb begin
            w_code    = '0;
            w_pending = 1'b0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (bus.id_rs_used[i] && match(w_stg[s].reg_we, bus.id_rs[i], w_stg[s].rd)) begin
                    w_code    = FWD_W'(s + 1);
                    w_pending = !w_stg[s].data_ready;
                end
            end
        end

        assign w_sel[i]      = w_code;
        assign w_load_use[i] = w_pending;
        assign w_src_busy[i] = bus.id_rs_used[i] && w_busy_eff[bus.id_rs[i]];
    end

    forwarding_hazard_unit_mc_scoreboard #(
        .MC_DEPTH (MC_DEPTH)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_issue      (w_issue),
        .i_issue_rd   (bus.id_rd),
        .i_done       (bus.mc_done),
        .i_done_rd    (bus.mc_done_rd),
        .o_busy_eff_c (w_busy_eff),
        .o_full_c     (w_full),
        .o_busy_c     (w_mc_busy)
    );

    assign w_sb_hazard = (|w_src_busy) || w_busy_eff[bus.id_rd] || (bus.id_is_mc && w_full);
    assign w_stall     = reset_n && bus.id_valid && !bus.flush && ((|w_load_use) || w_sb_hazard);
    assign w_accept    = bus.id_valid && !w_stall && !bus.flush;
    assign w_issue     = w_accept && bus.id_is_mc;

    // Stalled or flushed decode reaches Ex as a bubble with no forwarding.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_forward_rs   <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_forward_rs <= w_accept ? w_sel : '0;
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.forward_rs   = r_forward_rs;
    assign bus.mc_busy      = w_mc_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
